// File: rtl/muldiv_pkg.sv
// Shared definitions for the EXE-stage HI/LO multiply/divide unit:
// op codes, FSM states, default width and the divide-by-zero quotient.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  // Quotient returned for a zero divisor; sliced down to XLEN by the user.
  localparam logic [63:0] DIV0_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Anything other than a move-to is iterated.
  function automatic logic is_arith(input logic [2:0] op);
    return (op != OP_MTHI) && (op != OP_MTLO);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Without the accumulate feature, op 7 degrades to MULTU and is unsigned.
  function automatic logic is_signed_op(input logic [2:0] op);
    logic s;
    case (op)
      OP_MULT, OP_DIV, OP_MADD: s = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MSUB: s = 1'b1;
`endif
      default: s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/exe_muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add for multiply, restoring
// subtract for divide. Purely combinational so several can be chained.
//   multiply: {acc,low} = partial product, low holds remaining multiplier bits
//   divide:   acc = partial remainder, low = dividend bits shifting into quotient
module exe_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN:0]   acc_in,
  input  logic [XLEN-1:0] low_in,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN:0]   acc_out,
  output logic [XLEN-1:0] low_out
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  // Compute both candidate iterations and select by operation.
  always_comb begin
    sum     = acc_in + (low_in[0] ? {1'b0, opnd} : '0);
    shifted = {acc_in[XLEN-1:0], low_in[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    if (is_div) begin
      if (diff[XLEN+1]) begin
        acc_out = shifted;
        low_out = {low_in[XLEN-2:0], 1'b0};
      end else begin
        acc_out = diff[XLEN:0];
        low_out = {low_in[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_out = {1'b0, sum[XLEN:1]};
      low_out = {sum[0], low_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative HI/LO multiply/divide unit in the EXE stage.
// Optional feature macro: MULDIV_MADD_EN (op 6/7 accumulate into HI:LO).
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no op in flight; MT ops write HI/LO directly
//   ST_ITER | STEPS_PC iterations per clock, down-counter to zero
//   ST_FIX  | sign correction, HI/LO written on leaving edge, done
module exe_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int STEPS_PC = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start_IN,
  input  logic [2:0]      op_IN,
  input  logic [XLEN-1:0] A_IN,
  input  logic [XLEN-1:0] B_IN,
  input  logic            flush_IN,
  input  logic            mf_req_IN,
  output logic            busy_OUT,
  output logic            done_OUT,
  output logic            stall_OUT,
  output logic [XLEN-1:0] HI_OUT,
  output logic [XLEN-1:0] LO_OUT
);

  localparam int ITERS = XLEN / STEPS_PC;
  localparam int CW    = $clog2(ITERS);

  state_e          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_r;
  logic            div_r, neg_q, neg_r, b_zero;
  logic [XLEN:0]   acc;
  logic [XLEN-1:0] low, opnd, hi, lo;

  logic            accept, load, write_res, mt_wr;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] res_hi, res_lo;

  logic [XLEN:0]   chain_acc [0:STEPS_PC];
  logic [XLEN-1:0] chain_low [0:STEPS_PC];

  assign chain_acc[0] = acc;
  assign chain_low[0] = low;

  for (genvar g = 0; g < STEPS_PC; g++) begin : g_step
    exe_muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div  (div_r),
      .acc_in  (chain_acc[g]),
      .low_in  (chain_low[g]),
      .opnd    (opnd),
      .acc_out (chain_acc[g+1]),
      .low_out (chain_low[g+1])
    );
  end

  // Operand magnitudes and sign flags captured at issue.
  always_comb begin
    sign_a = is_signed_op(op_IN) & A_IN[XLEN-1];
    sign_b = is_signed_op(op_IN) & B_IN[XLEN-1];
    abs_a  = sign_a ? -A_IN : A_IN;
    abs_b  = sign_b ? -B_IN : B_IN;
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and control strobes; flush outranks any start.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    write_res = 1'b0;
    mt_wr     = 1'b0;
    accept    = start_IN & ~flush_IN;
    case (state)
      ST_IDLE: begin
        if (accept && is_arith(op_IN)) begin
          load      = 1'b1;
          state_nxt = ST_ITER;
        end else if (accept) begin
          mt_wr = 1'b1;
        end
      end
      ST_ITER: begin
        if (flush_IN)       state_nxt = ST_IDLE;
        else if (cnt == '0) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        if (flush_IN) begin
          state_nxt = ST_IDLE;
        end else begin
          write_res = 1'b1;
          state_nxt = ST_IDLE;
          if (accept && is_arith(op_IN)) begin
            load      = 1'b1;
            state_nxt = ST_ITER;
          end else if (accept) begin
            mt_wr = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Iteration datapath: load magnitudes at issue, advance the chain in ITER.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt    <= '0;
      op_r   <= '0;
      div_r  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      acc    <= '0;
      low    <= '0;
      opnd   <= '0;
    end else if (load) begin
      cnt    <= CW'(ITERS - 1);
      op_r   <= op_IN;
      div_r  <= is_div_op(op_IN);
      neg_q  <= sign_a ^ sign_b;
      neg_r  <= sign_a;
      b_zero <= (B_IN == '0);
      acc    <= '0;
      if (is_div_op(op_IN)) begin
        low  <= abs_a;
        opnd <= abs_b;
      end else begin
        low  <= abs_b;
        opnd <= abs_a;
      end
    end else if (state == ST_ITER) begin
      cnt <= cnt - CW'(1);
      acc <= chain_acc[STEPS_PC];
      low <= chain_low[STEPS_PC];
    end
  end

  // Final sign correction and optional accumulate.
  always_comb begin
    logic [2*XLEN-1:0] prod_mag, prod;
    logic [XLEN-1:0]   quo, rem;
    prod_mag = {acc[XLEN-1:0], low};
    prod     = neg_q ? -prod_mag : prod_mag;
    quo      = neg_q ? -low : low;
    rem      = neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    res_hi   = prod[2*XLEN-1:XLEN];
    res_lo   = prod[XLEN-1:0];
    if (div_r) begin
      res_hi = rem;
      res_lo = b_zero ? DIV0_QUOT[XLEN-1:0] : quo;
    end
`ifdef MULDIV_MADD_EN
    else if (op_r == OP_MADD) begin
      {res_hi, res_lo} = {hi, lo} + prod;
    end else if (op_r == OP_MSUB) begin
      {res_hi, res_lo} = {hi, lo} - prod;
    end
`endif
  end

  // Architectural HI/LO; a move-to issued in the FIX cycle lands after the result.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (write_res) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (mt_wr) begin
        if (op_IN == OP_MTHI) hi <= A_IN;
        else                  lo <= A_IN;
      end
    end
  end

  assign busy_OUT = (state == ST_ITER);
  assign done_OUT = (state == ST_FIX) & ~flush_IN;
  assign HI_OUT   = hi;
  assign LO_OUT   = lo;

  // HI/LO only change on the edge closing the FIX cycle, so MF stalls through it.
  assign stall_OUT = mf_req_IN & (busy_OUT | done_OUT | (start_IN & is_arith(op_IN)));

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_exe_muldiv;

  localparam int ITERS = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        flush = 1'b0;
  logic        mf_req = 1'b0;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] hi_m = '0, lo_m = '0;
  logic [63:0] exp_v;
  logic [2:0]  rop;
  logic [31:0] ra, rb;
  int          edges, busy_n, stall_n, done_n;
  bit          ok;

  exe_muldiv #(.XLEN(32), .STEPS_PC(1)) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .start_IN  (start),
    .op_IN     (op),
    .A_IN      (a),
    .B_IN      (b),
    .flush_IN  (flush),
    .mf_req_IN (mf_req),
    .busy_OUT  (busy),
    .done_OUT  (done),
    .stall_OUT (stall),
    .HI_OUT    (hi),
    .LO_OUT    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Architectural result of one op given the current HI/LO.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y, h, l);
    longint sx, sy, q, m;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    case (o)
      3'd0: r = sx * sy;
      3'd1: r = {32'b0, x} * {32'b0, y};
      3'd2: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
      3'd3: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      3'd4: r = {x, l};
      3'd5: r = {h, x};
`ifdef MULDIV_MADD_EN
      3'd6: r = {h, l} + 64'(sx * sy);
      3'd7: r = {h, l} - 64'(sx * sy);
`else
      3'd6: r = sx * sy;
      3'd7: r = {32'b0, x} * {32'b0, y};
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done; report ITER edges seen and cycles with busy high.
  task automatic wait_done(output int n_edges, output int n_busy, output bit seen);
    n_edges = 0;
    n_busy  = 0;
    while (!done && n_edges < 200) begin
      if (busy) n_busy++;
      tick();
      n_edges++;
    end
    seen = done;
    if (!seen) chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, y);
    logic [63:0] e;
    int ne, nb;
    bit s;
    e = model(o, x, y, hi_m, lo_m);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    if (o == 3'd4 || o == 3'd5) begin
      chk("mt_hi", 64'(hi), 64'(e[63:32]));
      chk("mt_lo", 64'(lo), 64'(e[31:0]));
      chk("mt_busy", 64'(busy), 64'd0);
    end else begin
      wait_done(ne, nb, s);
      if (s) begin
        chk("done_old_hi", 64'(hi), 64'(hi_m));
        tick();
        chk("res_hi", 64'(hi), 64'(e[63:32]));
        chk("res_lo", 64'(lo), 64'(e[31:0]));
        chk("done_pulse", 64'(done), 64'd0);
        chk("latency", 64'(ne + 1), 64'(ITERS + 1));
        chk("busy_cycles", 64'(nb), 64'(ITERS));
      end
    end
    hi_m = e[63:32];
    lo_m = e[31:0];
  endtask

  initial begin
    // Reset state.
    #12;
    mf_req = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    mf_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors.
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_neg2x3_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_lo", 64'(lo), 64'hFFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd0);
    chk("divu_by0_lo", 64'(lo), 64'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'd0);

    // MF stall across an in-flight multiply.
    run_op(3'd4, 32'h1234, 32'd0);
    exp_v = model(3'd0, 32'd3, 32'd5, hi_m, lo_m);
    mf_req = 1'b1; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    #1;
    chk("stall_at_issue", 64'(stall), 64'd1);
    tick();
    start = 1'b0;
    stall_n = 0;
    edges = 0;
    while (stall && edges < 100) begin
      if (done) chk("stall_done_old_hi", 64'(hi), 64'(hi_m));
      stall_n++;
      edges++;
      tick();
    end
    chk("stall_cycles", 64'(stall_n), 64'(ITERS + 1));
    chk("stall_res_lo", 64'(lo), 64'(exp_v[31:0]));
    hi_m = exp_v[63:32];
    lo_m = exp_v[31:0];
    mf_req = 1'b0;

    // Flush mid-op leaves HI/LO untouched.
    run_op(3'd4, 32'h1234, 32'd0);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    done_n = 0;
    repeat (40) begin
      if (done) done_n++;
      tick();
    end
    chk("flush_no_done", 64'(done_n), 64'd0);
    chk("flush_hi_kept", 64'(hi), 64'h1234);
    chk("flush_lo_kept", 64'(lo), 64'(lo_m));

    // Back-to-back: next op accepted in the done cycle.
    exp_v = model(3'd1, 32'd5, 32'd6, hi_m, lo_m);
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
    tick();
    start = 1'b0;
    wait_done(edges, busy_n, ok);
    if (ok) begin
      start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      tick();
      start = 1'b0;
      chk("b2b_first_lo", 64'(lo), 64'(exp_v[31:0]));
      chk("b2b_first_hi", 64'(hi), 64'(exp_v[63:32]));
      chk("b2b_accepted", 64'(busy), 64'd1);
      wait_done(edges, busy_n, ok);
      if (ok) begin
        tick();
        chk("b2b_second_lo", 64'(lo), 64'd14);
        chk("b2b_second_hi", 64'(hi), 64'd2);
      end
    end
    hi_m = 32'd2;
    lo_m = 32'd14;

    // Accumulate ops (or their plain-multiply fallback).
    run_op(3'd4, 32'd0, 32'd0);
    run_op(3'd5, 32'd1, 32'd0);
    run_op(3'd6, 32'd2, 32'd3);
`ifdef MULDIV_MADD_EN
    chk("madd_lo", 64'(lo), 64'd7);
`else
    chk("op6_as_mult_lo", 64'(lo), 64'd6);
`endif
    run_op(3'd7, 32'hFFFF_FFFF, 32'd2);

    // Random ops against the model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFF_FFFF;
      run_op(rop, ra, rb);
    end

    // Asynchronous reset in the middle of an iteration.
    start = 1'b1; op = 3'd1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hi_m = '0;
    lo_m = '0;
    tick();
    run_op(3'd0, 32'd9, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
